// File: rtl/ysyx_23060208_mem_arbiter_pkg.sv
// rtl/ysyx_23060208_mem_arbiter_pkg.sv - shared encodings for the IFU/LSU memory arbiter
package ysyx_23060208_mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060208_mem_arbiter_if.sv
// rtl/ysyx_23060208_mem_arbiter_if.sv - request/response bus shared by IFU, LSU and memory port
interface ysyx_23060208_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wen;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ysyx_23060208_mem_arbiter.sv
// rtl/ysyx_23060208_mem_arbiter.sv - round-robin IFU/LSU arbiter onto a single memory port
module ysyx_23060208_mem_arbiter
  import ysyx_23060208_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic                          clock,
  input logic                          reset,
  ysyx_23060208_mem_arbiter_if.slave   ifu,
  ysyx_23060208_mem_arbiter_if.slave   lsu,
  ysyx_23060208_mem_arbiter_if.master  mem
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       owner_req_valid;

  // The IFU is read-only; its write-side fields are never forwarded.
  logic unused_ifu_write;
  assign unused_ifu_write = ^{ifu.req_wen, ifu.req_wdata, ifu.req_wstrb};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_IFU;
      last_owner_q <= OWNER_IFU;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    owner_req_valid = (owner_q == OWNER_LSU) ? lsu.req_valid : ifu.req_valid;

    mem.req_valid   = 1'b0;
    mem.req_wen     = 1'b0;
    mem.req_addr    = {ADDR_WIDTH{1'b0}};
    mem.req_wdata   = {DATA_WIDTH{1'b0}};
    mem.req_wstrb   = {STRB_WIDTH{1'b0}};
    mem.resp_ready  = 1'b0;
    ifu.req_ready   = 1'b0;
    ifu.resp_valid  = 1'b0;
    ifu.resp_data   = {DATA_WIDTH{1'b0}};
    lsu.req_ready   = 1'b0;
    lsu.resp_valid  = 1'b0;
    lsu.resp_data   = {DATA_WIDTH{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (ifu.req_valid || lsu.req_valid) begin
          state_d = ST_REQ;
          // On a tie the master that did not win last time is granted.
          owner_d = (ifu.req_valid && lsu.req_valid) ? ~last_owner_q : lsu.req_valid;
        end
      end
      ST_REQ: begin
        mem.req_valid = owner_req_valid;
        if (owner_q == OWNER_LSU) begin
          mem.req_wen   = lsu.req_wen;
          mem.req_addr  = lsu.req_addr;
          mem.req_wdata = lsu.req_wdata;
          mem.req_wstrb = lsu.req_wstrb;
          lsu.req_ready = mem.req_ready;
        end else begin
          mem.req_addr  = ifu.req_addr;
          ifu.req_ready = mem.req_ready;
        end
        if (!owner_req_valid) begin
          state_d = ST_IDLE;
        end else if (mem.req_ready) begin
          state_d      = ST_RESP;
          last_owner_d = owner_q;
        end
      end
      ST_RESP: begin
        if (owner_q == OWNER_LSU) begin
          mem.resp_ready = lsu.resp_ready;
          lsu.resp_valid = mem.resp_valid;
          lsu.resp_data  = mem.resp_data;
        end else begin
          mem.resp_ready = ifu.resp_ready;
          ifu.resp_valid = mem.resp_valid;
          ifu.resp_data  = mem.resp_data;
        end
        if (mem.resp_valid && mem.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// tb/tb_ysyx_23060208_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter
module tb_ysyx_23060208_mem_arbiter;
  import ysyx_23060208_mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_23060208_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifu_bus ();
  ysyx_23060208_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_bus ();
  ysyx_23060208_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  ysyx_23060208_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .ifu   (ifu_bus),
    .lsu   (lsu_bus),
    .mem   (mem_bus)
  );

  typedef struct {
    logic        owner;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic model_last = OWNER_IFU;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic own_req_ready(input logic o);
    return o ? lsu_bus.req_ready : ifu_bus.req_ready;
  endfunction
  function automatic logic own_resp_valid(input logic o);
    return o ? lsu_bus.resp_valid : ifu_bus.resp_valid;
  endfunction
  function automatic logic [31:0] own_resp_data(input logic o);
    return o ? lsu_bus.resp_data : ifu_bus.resp_data;
  endfunction

  function automatic logic [159:0] all_outs();
    return {mem_bus.req_valid, mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata,
            mem_bus.req_wstrb, mem_bus.resp_ready, ifu_bus.req_ready, ifu_bus.resp_valid,
            ifu_bus.resp_data, lsu_bus.req_ready, lsu_bus.resp_valid, lsu_bus.resp_data};
  endfunction

  task automatic push_ifu(input logic [31:0] addr, input logic [31:0] rdata);
    txn_t e;
    e = '{owner: OWNER_IFU, wen: 1'b0, addr: addr, wdata: 32'h0, wstrb: 4'h0, rdata: rdata};
    exp_q.push_back(e);
  endtask

  task automatic push_lsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] rdata);
    txn_t e;
    e = '{owner: OWNER_LSU, wen: wen, addr: addr, wdata: wdata, wstrb: wstrb,
          rdata: (wen ? 32'h0 : rdata)};
    exp_q.push_back(e);
  endtask

  // IFU write fields carry junk so that any leak onto the memory port shows up.
  task automatic drive_ifu(input logic [31:0] addr);
    ifu_bus.req_valid = 1'b1;
    ifu_bus.req_addr  = addr;
    ifu_bus.req_wen   = 1'b1;
    ifu_bus.req_wdata = 32'hFFFF_FFFF;
    ifu_bus.req_wstrb = 4'hF;
  endtask

  task automatic drive_lsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    lsu_bus.req_valid = 1'b1;
    lsu_bus.req_wen   = wen;
    lsu_bus.req_addr  = addr;
    lsu_bus.req_wdata = wdata;
    lsu_bus.req_wstrb = wstrb;
  endtask

  task automatic issue_ifu(input logic [31:0] addr, input logic [31:0] rdata);
    push_ifu(addr, rdata);
    drive_ifu(addr);
  endtask

  task automatic issue_lsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] rdata);
    push_lsu(wen, addr, wdata, wstrb, rdata);
    drive_lsu(wen, addr, wdata, wstrb);
  endtask

  task automatic issue_pair(input logic [31:0] iaddr, input logic [31:0] idata,
                            input logic [31:0] laddr, input logic [31:0] ldata);
    if (model_last == OWNER_IFU) begin
      push_lsu(1'b0, laddr, 32'h0, 4'hF, ldata);
      push_ifu(iaddr, idata);
    end else begin
      push_ifu(iaddr, idata);
      push_lsu(1'b0, laddr, 32'h0, 4'hF, ldata);
    end
    drive_ifu(iaddr);
    drive_lsu(1'b0, laddr, 32'h0, 4'hF);
  endtask

  // Memory-side model: pops the next expected transaction and plays the slave.
  task automatic serve(input int req_stall, input int resp_stall);
    txn_t e;
    int   n;
    logic other;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 160'(exp_q.size()), 160'd1);
      return;
    end
    e = exp_q.pop_front();
    other = ~e.owner;
    n = 0;
    while (!mem_bus.req_valid && n < 20) begin
      step();
      n++;
    end
    chk("grant_latency", 160'(n), 160'd1);
    for (int i = 0; i < req_stall; i++) begin
      chk("stall_fields", {mem_bus.req_valid, mem_bus.req_addr, own_req_ready(e.owner)},
          {1'b1, e.addr, 1'b0});
      step();
    end
    mem_bus.req_ready = 1'b1;
    #1;
    chk("req_fields", {mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wstrb},
        {e.wen, e.addr, e.wdata, e.wstrb});
    chk("req_ready_route", {own_req_ready(e.owner), own_req_ready(other)}, {1'b1, 1'b0});
    step();
    mem_bus.req_ready = 1'b0;
    if (e.owner == OWNER_LSU) lsu_bus.req_valid = 1'b0;
    else ifu_bus.req_valid = 1'b0;
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_data  = e.rdata;
    #1;
    for (int i = 0; i < resp_stall; i++) begin
      chk("resp_stall", {mem_bus.req_valid, own_resp_valid(e.owner), own_resp_valid(other),
                         mem_bus.resp_ready}, {1'b0, 1'b1, 1'b0, 1'b0});
      step();
    end
    if (e.owner == OWNER_LSU) lsu_bus.resp_ready = 1'b1;
    else ifu_bus.resp_ready = 1'b1;
    #1;
    chk("resp_route", {own_resp_valid(e.owner), own_resp_data(e.owner), mem_bus.resp_ready},
        {1'b1, e.rdata, 1'b1});
    chk("resp_other", {own_resp_valid(other), own_resp_data(other)}, {1'b0, 32'h0});
    step();
    mem_bus.resp_valid = 1'b0;
    ifu_bus.resp_ready = 1'b0;
    lsu_bus.resp_ready = 1'b0;
    #1;
    chk("back_to_idle", {mem_bus.req_valid, mem_bus.resp_ready}, 160'd0);
    model_last = e.owner;
  endtask

  initial begin
    ifu_bus.req_valid = 0; ifu_bus.req_wen = 0; ifu_bus.req_addr = 0;
    ifu_bus.req_wdata = 0; ifu_bus.req_wstrb = 0; ifu_bus.resp_ready = 0;
    lsu_bus.req_valid = 0; lsu_bus.req_wen = 0; lsu_bus.req_addr = 0;
    lsu_bus.req_wdata = 0; lsu_bus.req_wstrb = 0; lsu_bus.resp_ready = 0;
    mem_bus.req_ready = 0; mem_bus.resp_valid = 0; mem_bus.resp_data = 0;
    reset = 1'b1;
    step();
    step();
    chk("reset_outputs", all_outs(), 160'd0);
    reset = 1'b0;
    step();

    // Contention straight after reset, repeated to show alternation.
    issue_pair(32'h8000_0010, 32'h1111_0001, 32'h8000_3000, 32'h2222_0001);
    serve(0, 0);
    serve(0, 0);
    issue_pair(32'h8000_0014, 32'h1111_0002, 32'h8000_3004, 32'h2222_0002);
    serve(0, 0);
    serve(0, 0);

    issue_ifu(32'h8000_0000, 32'h0000_0413);
    serve(0, 0);

    issue_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 32'h0);
    serve(0, 0);

    issue_lsu(1'b0, 32'h8000_2000, 32'h0, 4'hF, 32'hCAFE_F00D);
    serve(0, 0);

    issue_ifu(32'h8000_0040, 32'h0051_0113);
    serve(5, 3);

    // Reset while the response is pending abandons the transaction.
    drive_ifu(32'h8000_0100);
    step();
    mem_bus.req_ready = 1'b1;
    step();
    mem_bus.req_ready  = 1'b0;
    ifu_bus.req_valid  = 1'b0;
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_data  = 32'h1234_5678;
    #1;
    chk("resp_before_reset", {ifu_bus.resp_valid, ifu_bus.resp_data}, {1'b1, 32'h1234_5678});
    reset = 1'b1;
    step();
    chk("mid_reset_outputs", all_outs(), 160'd0);
    reset = 1'b0;
    mem_bus.resp_valid = 1'b0;
    model_last = OWNER_IFU;
    issue_ifu(32'h8000_0200, 32'h0000_0093);
    serve(0, 0);

    // Stray response while idle must be neither accepted nor forwarded.
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_data  = 32'hBAD0_BAD0;
    #1;
    chk("spurious_resp", {mem_bus.resp_ready, ifu_bus.resp_valid, lsu_bus.resp_valid},
        160'd0);
    step();
    chk("spurious_idle", {mem_bus.req_valid, mem_bus.resp_ready, ifu_bus.resp_valid,
                          lsu_bus.resp_valid}, 160'd0);
    mem_bus.resp_valid = 1'b0;
    step();

    chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
